regfile_wb_ctrl: RTL and testbench
==================================

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL take parameter XLEN, default 32, register data width.
REQ-002 SHALL take parameter NREG, default 32, architectural register count; REG_AW = log2(NREG) = 5.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 iss_valid  input  1  decode presents an instruction for issue.
REQ-006 iss_rs1, iss_rs2, iss_rd  input  REG_AW each  source and destination registers of that instruction.
REQ-007 stall  output  1  issue blocked this cycle (combinational).
REQ-008 alu_valid, alu_rd, alu_data  input  1/REG_AW/XLEN  ALU writeback request.
REQ-009 alu_ready  output  1  ALU request accepted this cycle.
REQ-010 lsu_valid, lsu_rd, lsu_data  input  1/REG_AW/XLEN  load-unit writeback request.
REQ-011 lsu_ready  output  1  load request accepted this cycle.
REQ-012 wb_we, wb_addr, wb_data  output  1/REG_AW/XLEN  registered drive of the register file write port.
REQ-013 busy  output  NREG  pending-write scoreboard, bit r = write to r outstanding.
REQ-014 err  output  1  sticky: writeback accepted to a register not marked busy.

Function
REQ-015 Issue accepted when iss_valid && !stall; on accept busy[iss_rd] sets at the next edge, except iss_rd==0.
REQ-016 stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]) (RAW and WAW); bit 0 of busy always 0.
REQ-017 Requesters hold rd/data stable while valid && !ready; handshake completes on valid && ready at a rising edge.
REQ-018 Arbitration: one grant per cycle; ready asserted combinationally from valid and the priority bit; a lone requester is granted the same cycle.
REQ-019 Round-robin: priority bit prio (0 = ALU preferred); when both valid, the preferred one is granted; after any grant prio points to the non-granted requester.
REQ-020 Granted request registers to wb_addr/wb_data one cycle later with wb_we=1 (latency 1); no grant -> wb_we=0, wb_addr/wb_data hold.
REQ-021 rd==0 request: ready asserted normally, wb_we stays 0, scoreboard and err untouched.
REQ-022 busy[r] clears at the edge where wb_we=1 and wb_addr=r (same edge the register file writes), so a read after clear sees new data.
REQ-023 Same-edge set (issue of rd=r) and clear (writeback of r): set wins, busy[r] stays 1.
REQ-024 Grant to rd with busy[rd]==0 sets err; err clears only on reset.
REQ-025 Back-to-back grants every cycle SHALL be sustained with no bubble.

Reset
REQ-026 While rst low: wb_we=0, wb_addr=0, wb_data=0, busy=0, prio=0, err=0, alu_ready=0, lsu_ready=0, stall=0.
REQ-027 Reset asserted mid-operation drops all pending requests and scoreboard state immediately (asynchronous); no write issued after reset release until a new grant.

Structure
REQ-028 XLEN, NREG, REG_AW and requester index enum (REQ_ALU=0, REQ_LSU=1) SHALL live in shared package rv_pkg.
REQ-029 Arbitration SHALL be a sub-module rr_arb2 (2 requests, 2 one-hot grants, internal prio flop); scoreboard and write-port registers stay in regfile_wb_ctrl.

Verification
REQ-030 Issue rd=5, then rs1=5 next cycle -> stall=1; ALU writeback rd=5 data 0xDEADBEEF -> wb_we=1, wb_addr=5, wb_data=0xDEADBEEF one cycle later; stall drops the cycle after.
REQ-031 ALU and LSU both valid 4 cycles after reset (rd=1,2 pending) -> grants ALU, LSU, ALU, LSU alternating; no bubble on wb_we.
REQ-032 LSU rd=0 data 0x1234 -> lsu_ready=1, wb_we stays 0, err stays 0.
REQ-033 Writeback rd=7 same edge as issue rd=7 -> busy[7]=1 after edge; ALU writeback rd=9 with busy[9]=0 -> err=1 and held.
REQ-034 Assert rst low mid-cycle with busy=0x0000_0024 and both requests valid -> busy=0, wb_we=0, readies 0 immediately; after release, first grant goes to ALU.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared sizing constants and requester indices for the register-file
// writeback controller and its arbiter.
package rv_pkg;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_idx_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, a single
// priority flop that points at the requester that lost the last grant.
module rr_arb2
  import rv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       prio_o
);

  logic prio_q;

  // Grants are forced low while reset is held so readies drop immediately.
  always_comb begin
    gnt_o = 2'b00;
    if (rst_n) begin
      if (req_i == 2'b11) gnt_o = prio_q ? 2'b10 : 2'b01;
      else                gnt_o = req_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (gnt_o[REQ_ALU]) begin
      prio_q <= 1'b1;
    end else if (gnt_o[REQ_LSU]) begin
      prio_q <= 1'b0;
    end
  end

  assign prio_o = prio_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: pending-write scoreboard with issue
// stall, two-source writeback arbitration and a registered write port.
module regfile_wb_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = rv_pkg::NREG,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  output logic            stall,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            wb_we,
  output logic [AW-1:0]   wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic [NREG-1:0] busy,
  output logic            err
);

  // Handshake: a requester holds rd/data stable while valid && !ready; the
  // transfer happens on the rising edge where valid && ready are both high.

  logic [1:0]      req, gnt;
  logic            prio_dbg;
  logic [NREG-1:0] busy_q, busy_d;
  logic            wb_we_q, err_q;
  logic [AW-1:0]   wb_addr_q, win_rd;
  logic [XLEN-1:0] wb_data_q, win_data;
  logic            wr_en, iss_acc;

  assign req[REQ_ALU] = alu_valid;
  assign req[REQ_LSU] = lsu_valid;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst),
    .req_i  (req),
    .gnt_o  (gnt),
    .prio_o (prio_dbg)
  );

  assign alu_ready = gnt[REQ_ALU];
  assign lsu_ready = gnt[REQ_LSU];

  assign win_rd   = gnt[REQ_LSU] ? lsu_rd   : alu_rd;
  assign win_data = gnt[REQ_LSU] ? lsu_data : alu_data;
  // Writes to x0 complete the handshake but never reach the port.
  assign wr_en    = (|gnt) && (win_rd != '0);

  assign stall   = rst && iss_valid &&
                   (busy_q[iss_rs1] || busy_q[iss_rs2] || busy_q[iss_rd]);
  assign iss_acc = iss_valid && !stall && (iss_rd != '0);

  // Clear is applied before set so a same-edge reissue keeps the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_we_q) busy_d[wb_addr_q] = 1'b0;
    if (iss_acc) busy_d[iss_rd]    = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      wb_we_q <= wr_en;
      if (wr_en) begin
        wb_addr_q <= win_rd;
        wb_data_q <= win_data;
        if (!busy_q[win_rd]) err_q <= 1'b1;
      end
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: scoreboard/stall, round-robin
// writeback ordering, x0 writes, error flag and asynchronous reset.
module tb_regfile_wb_ctrl;
  import rv_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            iss_valid;
  logic [4:0]      iss_rs1, iss_rs2, iss_rd;
  logic            stall;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [31:0]     alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [31:0]     lsu_data;
  logic            lsu_ready;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;
  logic [31:0]     busy;
  logic            err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];

  regfile_wb_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .stall     (stall),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .busy      (busy),
    .err       (err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    alu_valid = 1'b0; alu_rd  = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd  = '0; lsu_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1'b1; iss_rd = rd; iss_rs1 = '0; iss_rs2 = '0;
    tick();
    iss_valid = 1'b0;
  endtask

  logic [4:0]  a_rd [3];
  logic [31:0] a_dat[3];
  logic [4:0]  l_rd [3];
  logic [31:0] l_dat[3];
  logic [5:0]  exp_alu_gnt;
  logic [36:0] exp_wb;

  initial begin
    int ai, li;
    idle_inputs();
    rst = 1'b0;

    // reset state, with every request line high
    iss_valid = 1'b1; alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd3; lsu_rd = 5'd4;
    #2;
    check("rst_alu_ready", alu_ready, 0);
    check("rst_lsu_ready", lsu_ready, 0);
    check("rst_stall", stall, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    do_reset();

    // RAW stall and single ALU writeback
    issue(5'd5);
    check("raw_busy5", busy, 32'h0000_0020);
    iss_valid = 1'b1; iss_rs1 = 5'd5; iss_rd = 5'd6;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    #1;
    check("raw_stall", stall, 1);
    check("raw_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    check("raw_wb_we", wb_we, 1);
    check("raw_wb_addr", wb_addr, 5);
    check("raw_wb_data", wb_data, 32'hDEAD_BEEF);
    check("raw_stall_hold", stall, 1);
    tick();
    check("raw_stall_drop", stall, 0);
    check("raw_wb_we_idle", wb_we, 0);
    check("raw_wb_addr_hold", wb_addr, 5);
    tick();
    iss_valid = 1'b0;
    check("raw_busy6", busy, 32'h0000_0040);

    // round-robin, back-to-back writebacks
    do_reset();
    for (int r = 1; r <= 6; r++) issue(r[4:0]);
    check("rr_busy", busy, 32'h0000_007E);
    a_rd = '{5'd1, 5'd3, 5'd5}; a_dat = '{32'hA000_0001, 32'hA000_0003, 32'hA000_0005};
    l_rd = '{5'd2, 5'd4, 5'd6}; l_dat = '{32'hB000_0002, 32'hB000_0004, 32'hB000_0006};
    exp_alu_gnt = 6'b010101;
    ai = 0; li = 0;
    for (int k = 0; k < 6; k++) begin
      alu_valid = (ai < 3); lsu_valid = (li < 3);
      if (ai < 3) begin alu_rd = a_rd[ai]; alu_data = a_dat[ai]; end
      if (li < 3) begin lsu_rd = l_rd[li]; lsu_data = l_dat[li]; end
      #1;
      check($sformatf("rr_alu_ready_%0d", k), alu_ready, exp_alu_gnt[k]);
      check($sformatf("rr_lsu_ready_%0d", k), lsu_ready, !exp_alu_gnt[k]);
      if (exp_alu_gnt[k]) begin exp_q.push_back({a_rd[ai], a_dat[ai]}); ai++; end
      else                begin exp_q.push_back({l_rd[li], l_dat[li]}); li++; end
      tick();
      exp_wb = exp_q.pop_front();
      check($sformatf("rr_wb_we_%0d", k), wb_we, 1);
      check($sformatf("rr_wb_%0d", k), {wb_addr, wb_data}, exp_wb);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    check("rr_busy_clear", busy, 0);
    check("rr_err", err, 0);
    check("rr_wb_we_end", wb_we, 0);

    // LSU write to x0
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0000_1234;
    #1;
    check("x0_lsu_ready", lsu_ready, 1);
    tick();
    lsu_valid = 1'b0;
    check("x0_wb_we", wb_we, 0);
    check("x0_err", err, 0);
    check("x0_busy", busy, 0);

    // writeback to a register not busy -> sticky err
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999_0000;
    tick();
    alu_valid = 1'b0;
    check("err_set", err, 1);
    check("err_wb_addr", wb_addr, 9);
    repeat (3) tick();
    check("err_sticky", err, 1);

    // writeback of r7 on the same edge as issue of r7: set wins
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_7777;
    tick();
    alu_valid = 1'b0;
    check("same_wb_we", wb_we, 1);
    check("same_wb_addr", wb_addr, 7);
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    check("same_no_stall", stall, 0);
    tick();
    iss_valid = 1'b0;
    check("same_busy7", busy, 32'h0000_0080);

    // asynchronous reset in mid-operation
    do_reset();
    issue(5'd2);
    issue(5'd5);
    check("ar_busy", busy, 32'h0000_0024);
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hC0DE_0002;
    lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'hC0DE_0005;
    tick();
    check("ar_wb_we_pre", wb_we, 1);
    check("ar_lsu_ready_pre", lsu_ready, 1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_busy_clr", busy, 0);
    check("ar_wb_we", wb_we, 0);
    check("ar_alu_ready", alu_ready, 0);
    check("ar_lsu_ready", lsu_ready, 0);
    check("ar_wb_addr", wb_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ar_first_alu", alu_ready, 1);
    check("ar_first_lsu", lsu_ready, 0);
    check("ar_no_write", wb_we, 0);
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    check("ar_wb_we_post", wb_we, 1);
    check("ar_wb_addr_post", wb_addr, 2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
